// File: rtl/irq_ctrl_pkg.sv
// Package for the interrupt controller: register offsets, register selector
// enum and packed register layouts shared by the decoder and the top level.
package irq_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned IDX_W  = 5;

  // Word offsets, i.e. addr[4:2]
  localparam logic [OFF_W-1:0] OFF_CR   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_IER  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_IPR  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_ID   = 3'd3;
  localparam logic [OFF_W-1:0] OFF_TYPR = 3'd4;

  typedef enum logic [2:0] {
    IRQ_CTRL_CR,
    IRQ_CTRL_IER,
    IRQ_CTRL_IPR,
    IRQ_CTRL_ID,
    IRQ_CTRL_TYPR,
    IRQ_CTRL_NONE
  } irq_ctrl_reg_t;

  typedef struct packed {
    logic [30:0] rsvd;
    logic        gen;
  } cr_t;

  typedef struct packed {
    logic             valid;
    logic [25:0]      rsvd;
    logic [IDX_W-1:0] index;
  } id_t;

endpackage

// File: rtl/ibex_data_bus.sv
// Ibex-style data bus: request/grant address phase, rvalid response phase.
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/irq_ctrl_offset_decoder.sv
// Bus front end for irq_ctrl: grants every request in the same cycle,
// returns rvalid one cycle later and maps the word offset to a register.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req         bus request
//   offset      word offset (addr[4:2])
//   gnt_c       combinational grant (= req)
//   rvalid      response valid, registered
//   reg_sel_c   decoded register selector
// TYPR decodes only when IRQ_CTRL_LEVEL_EN is defined.
module irq_ctrl_offset_decoder
  import irq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [OFF_W-1:0] offset,
  output logic             gnt_c,
  output logic             rvalid,
  output irq_ctrl_reg_t    reg_sel_c
);

  assign gnt_c = req;

  // Every granted access, read or write, gets exactly one response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= req;
    end
  end

  // Offset to register selector; unmapped offsets select nothing
  always_comb begin
    reg_sel_c = IRQ_CTRL_NONE;
    case (offset)
      OFF_CR:   reg_sel_c = IRQ_CTRL_CR;
      OFF_IER:  reg_sel_c = IRQ_CTRL_IER;
      OFF_IPR:  reg_sel_c = IRQ_CTRL_IPR;
      OFF_ID:   reg_sel_c = IRQ_CTRL_ID;
`ifdef IRQ_CTRL_LEVEL_EN
      OFF_TYPR: reg_sel_c = IRQ_CTRL_TYPR;
`endif
      default:  reg_sel_c = IRQ_CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges of peripheral irq lines into a
// pending register, masks them per source and drives one request to the core.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   irq_src     peripheral irq lines (bit 0 = timer, highest priority)
//   irq         interrupt request to core (combinational from registers)
//   data_bus    ibex data bus slave: CR, IER, IPR (W1C), ID, [TYPR]
// Optional: IRQ_CTRL_LEVEL_EN adds TYPR at 0x10 for per-source level mode.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq,
  ibex_data_bus.slave      data_bus
);

  logic             gen_q;
  logic [N_SRC-1:0] ier_q;
  logic [N_SRC-1:0] ipr_q;
  logic [N_SRC-1:0] irq_src_q;
  logic [N_SRC-1:0] rise_c;
  logic [N_SRC-1:0] lvl_set_c;
  logic [N_SRC-1:0] w1c_c;
  logic [N_SRC-1:0] ipr_next_c;
  logic [N_SRC-1:0] active_c;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux_c;
  logic             wr_c;
  logic             rd_c;
  logic             gnt_c;
  logic             rvalid;
  irq_ctrl_reg_t    reg_sel_c;
  cr_t              cr_c;
  id_t              id_c;
  logic             unused_bus;

  irq_ctrl_offset_decoder u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (data_bus.req),
    .offset    (data_bus.addr[4:2]),
    .gnt_c     (gnt_c),
    .rvalid    (rvalid),
    .reg_sel_c (reg_sel_c)
  );

  assign data_bus.gnt    = gnt_c;
  assign data_bus.rvalid = rvalid;
  assign data_bus.rdata  = rdata_q;
  assign data_bus.err    = 1'b0;

  // Byte enables and address bits outside the word offset play no part
  assign unused_bus = ^{data_bus.be, data_bus.addr[ADDR_W-1:5],
                        data_bus.addr[1:0], data_bus.wdata};

  assign wr_c = data_bus.req & data_bus.we;
  assign rd_c = data_bus.req & ~data_bus.we;

  assign rise_c = irq_src & ~irq_src_q;
  assign w1c_c  = (wr_c && reg_sel_c == IRQ_CTRL_IPR) ? data_bus.wdata[N_SRC-1:0]
                                                       : '0;

`ifdef IRQ_CTRL_LEVEL_EN
  logic [N_SRC-1:0] typr_q;

  // Level sources re-pend every cycle the line is high
  assign lvl_set_c = typr_q & irq_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typr_q <= '0;
    end else if (wr_c && reg_sel_c == IRQ_CTRL_TYPR) begin
      typr_q <= data_bus.wdata[N_SRC-1:0];
    end
  end
`else
  assign lvl_set_c = '0;
`endif

  // Set beats clear: a new rise in the W1C cycle keeps the bit pending
  assign ipr_next_c = (ipr_q & ~w1c_c) | rise_c | lvl_set_c;
  assign active_c   = ipr_q & ier_q;
  assign irq        = gen_q & (|active_c);

  // Control and pending state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q     <= 1'b0;
      ier_q     <= '0;
      ipr_q     <= '0;
      irq_src_q <= '0;
    end else begin
      irq_src_q <= irq_src;
      ipr_q     <= ipr_next_c;
      if (wr_c && reg_sel_c == IRQ_CTRL_CR) begin
        gen_q <= data_bus.wdata[0];
      end
      if (wr_c && reg_sel_c == IRQ_CTRL_IER) begin
        ier_q <= data_bus.wdata[N_SRC-1:0];
      end
    end
  end

  // Priority encoder: lowest active index wins, scanned from the top down
  always_comb begin
    id_c = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active_c[i]) begin
        id_c.valid = 1'b1;
        id_c.index = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cr_c      = '0;
    cr_c.gen  = gen_q;
  end

  // Read data selection
  always_comb begin
    rd_mux_c = '0;
    case (reg_sel_c)
      IRQ_CTRL_CR:   rd_mux_c = DATA_W'(cr_c);
      IRQ_CTRL_IER:  rd_mux_c = DATA_W'(ier_q);
      IRQ_CTRL_IPR:  rd_mux_c = DATA_W'(ipr_q);
      IRQ_CTRL_ID:   rd_mux_c = DATA_W'(id_c);
`ifdef IRQ_CTRL_LEVEL_EN
      IRQ_CTRL_TYPR: rd_mux_c = DATA_W'(typr_q);
`endif
      default:       rd_mux_c = '0;
    endcase
  end

  // Read data is captured on the granted read and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_c) begin
      rdata_q <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed register scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam int unsigned NS = 8;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] irq_src;
  logic          irq;

  ibex_data_bus bus ();

  irq_ctrl #(.N_SRC(NS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .irq      (irq),
    .data_bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_gen  = 1'b0;
  bit [NS-1:0] m_ier  = '0;
  bit [NS-1:0] m_ipr  = '0;
  bit [NS-1:0] m_typr = '0;
  bit [NS-1:0] m_prev = '0;
  bit          m_rvalid = 1'b0;
  bit [31:0]   m_rdata  = '0;

  function automatic bit [31:0] m_id();
    bit [31:0] r;
    r = 32'h0;
    for (int i = 0; i < int'(NS); i++) begin
      if (m_ipr[i] && m_ier[i]) begin
        r = 32'h8000_0000 + 32'(i);
        break;
      end
    end
    return r;
  endfunction

  function automatic bit [31:0] m_read(input int off);
    case (off)
      0: return {31'b0, m_gen};
      1: return 32'(m_ier);
      2: return 32'(m_ipr);
      3: return m_id();
`ifdef IRQ_CTRL_LEVEL_EN
      4: return 32'(m_typr);
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gen = 0; m_ier = '0; m_ipr = '0; m_typr = '0; m_prev = '0;
      m_rvalid = 0; m_rdata = '0;
    end else begin
      int off;
      bit [NS-1:0] nipr;
      off = int'(bus.addr[4:2]);
      m_rvalid = bus.req;
      if (bus.req && !bus.we) m_rdata = m_read(off);
      nipr = m_ipr;
      if (bus.req && bus.we && off == 2) nipr = nipr & ~bus.wdata[NS-1:0];
      for (int i = 0; i < int'(NS); i++) begin
        if (irq_src[i] && !m_prev[i]) nipr[i] = 1'b1;
`ifdef IRQ_CTRL_LEVEL_EN
        if (m_typr[i] && irq_src[i]) nipr[i] = 1'b1;
`endif
      end
      if (bus.req && bus.we) begin
        if (off == 0) m_gen = bus.wdata[0];
        if (off == 1) m_ier = bus.wdata[NS-1:0];
`ifdef IRQ_CTRL_LEVEL_EN
        if (off == 4) m_typr = bus.wdata[NS-1:0];
`endif
      end
      m_ipr  = nipr;
      m_prev = irq_src;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    chk("irq", {31'b0, irq}, {31'b0, m_gen && ((m_ipr & m_ier) != '0)});
    chk("rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
    chk("gnt", {31'b0, bus.gnt}, {31'b0, bus.req});
    chk("err", {31'b0, bus.err}, 32'h0);
    if (m_rvalid) chk("rdata", bus.rdata, m_rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr_src(input int off, input logic [31:0] wd, input logic [NS-1:0] src);
    @(negedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'(off) << 2; bus.wdata = wd;
    irq_src = src;
    @(negedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_wr(input int off, input logic [31:0] wd);
    bus_wr_src(off, wd, irq_src);
  endtask

  task automatic rd_lit(input string name, input int off, input logic [31:0] exp);
    @(negedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'(off) << 2;
    @(negedge clk);
    chk(name, bus.rdata, exp);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic set_src(input logic [NS-1:0] v);
    @(negedge clk); #1;
    irq_src = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; irq_src = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'hF; bus.addr = '0; bus.wdata = '0;
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset state of every offset
    for (int o = 0; o < 8; o++) rd_lit("reset_rd", o, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // Single pulse on the timer source
    bus_wr(1, 32'h01);
    bus_wr(0, 32'h01);
    set_src(8'h01);
    set_src(8'h00);
    chk("pulse_irq", {31'b0, irq}, 32'h1);
    rd_lit("pulse_ipr", 2, 32'h01);
    rd_lit("pulse_id", 3, 32'h8000_0000);
    bus_wr(2, 32'h01);
    chk("w1c_irq", {31'b0, irq}, 32'h0);

    // Priority between two simultaneous sources
    bus_wr(1, 32'hFF);
    set_src(8'h24);
    set_src(8'h00);
    rd_lit("prio_id0", 3, 32'h8000_0002);
    bus_wr(2, 32'h04);
    rd_lit("prio_id1", 3, 32'h8000_0005);
    bus_wr(2, 32'h20);
    rd_lit("prio_id2", 3, 32'h0);
    chk("prio_irq", {31'b0, irq}, 32'h0);

    // Held source pends once while masked, fires on unmask
    bus_wr(1, 32'h00);
    set_src(8'h08);
    idle(10);
    rd_lit("held_ipr", 2, 32'h08);
    chk("held_irq0", {31'b0, irq}, 32'h0);
    bus_wr(1, 32'h08);
    chk("held_irq1", {31'b0, irq}, 32'h1);
    set_src(8'h00);
    bus_wr(2, 32'h08);
    rd_lit("held_ipr_clr", 2, 32'h0);

    // Set wins over clear in the same cycle
    set_src(8'h02);
    set_src(8'h00);
    bus_wr_src(2, 32'h02, 8'h02);
    rd_lit("setwin_ipr", 2, 32'h02);
    set_src(8'h00);
    bus_wr(2, 32'h02);
    rd_lit("setwin_clr", 2, 32'h0);

    // Bits above N_SRC, reserved CR bits and unmapped offsets
    bus_wr(1, 32'hFFFF_FFFF);
    rd_lit("ier_width", 1, 32'h0000_00FF);
    bus_wr(0, 32'hFFFF_FFFF);
    rd_lit("cr_width", 0, 32'h1);
    bus_wr(5, 32'hFFFF_FFFF);
    rd_lit("unmapped", 5, 32'h0);

`ifdef IRQ_CTRL_LEVEL_EN
    bus_wr(4, 32'h01);
    rd_lit("typr_rd", 4, 32'h01);
    set_src(8'h01);
    idle(2);
    bus_wr(2, 32'h01);
    rd_lit("lvl_hold", 2, 32'h01);
    set_src(8'h00);
    idle(1);
    bus_wr(2, 32'h01);
    rd_lit("lvl_clr", 2, 32'h0);
    bus_wr(4, 32'h00);
`else
    bus_wr(4, 32'hFF);
    rd_lit("typr_absent", 4, 32'h0);
`endif

    // Randomized traffic with a mid-run reset while a source is high
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      if (i == 400) begin
        irq_src = 8'h10;
        rst_n = 1'b0;
        bus.req = 1'b0;
        idle(2);
        rst_n = 1'b1;
        continue;
      end
      bus.req   = ($urandom_range(0, 2) == 0);
      bus.we    = $urandom_range(0, 1) == 1;
      bus.addr  = {27'($urandom), 3'($urandom_range(0, 7)), 2'b00};
      bus.wdata = $urandom;
      if (bus.we && bus.addr[4:2] == 3'd2 && $urandom_range(0, 1) == 1)
        bus.wdata = 32'($urandom_range(0, 255)) & 32'($urandom_range(0, 255));
      irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
    end
    bus.req = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
